// File: rtl/mul32_seq_pkg.sv
// rtl/mul32_seq_pkg.sv - shared types, widths and step helpers for mul32_seq_ctrl
package mul32_seq_pkg;

  localparam int HALF_W = 16;
  localparam int PP_W   = 32;
  localparam int ACC_W  = 64;

  localparam logic [5:0] SHIFT_LL = 6'd0;
  localparam logic [5:0] SHIFT_HL = 6'd16;
  localparam logic [5:0] SHIFT_LH = 6'd16;
  localparam logic [5:0] SHIFT_HH = 6'd32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    STEP_LL = 2'd0,
    STEP_HL = 2'd1,
    STEP_LH = 2'd2,
    STEP_HH = 2'd3
  } step_t;

  // Left shift applied to a step's partial product before accumulation.
  function automatic logic [5:0] step_shift(input step_t s);
    case (s)
      STEP_LL: return SHIFT_LL;
      STEP_HL: return SHIFT_HL;
      STEP_LH: return SHIFT_LH;
      default: return SHIFT_HH;
    endcase
  endfunction

  // Lowest-numbered step present in a step mask (bit index == step_t value).
  function automatic step_t first_step(input logic [3:0] m);
    if (m[0]) return STEP_LL;
    if (m[1]) return STEP_HL;
    if (m[2]) return STEP_LH;
    return STEP_HH;
  endfunction

  // Mask of steps strictly after s in LL/HL/LH/HH order.
  function automatic logic [3:0] later_steps(input step_t s);
    return 4'b1110 << s;
  endfunction

endpackage

// File: rtl/mul32_seq_ctrl_core.sv
// rtl/mul32_seq_ctrl_core.sv - combinational 16x16 unsigned multiplier core
module mul32_seq_ctrl_core
  import mul32_seq_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [PP_W-1:0]   p
);

  // Operands are zero-extended so the product is formed at full 32-bit width.
  assign p = {{(PP_W-HALF_W){1'b0}}, a} * {{(PP_W-HALF_W){1'b0}}, b};

endmodule

// File: rtl/mul32_seq_ctrl.sv
// rtl/mul32_seq_ctrl.sv - sequential 32x32 multiplier over one 16x16 core; optional MUL32_SEQ_ZERO_SKIP_EN
module mul32_seq_ctrl
  import mul32_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
);

  if (W != 32) begin : g_bad_width
    $error("mul32_seq_ctrl: W must be 32, the core is a fixed 16x16 instance");
  end

  state_t             state_q, state_d;
  step_t              step_q, step_d;
  logic [W-1:0]       a_q, b_q;
  logic [ACC_W-1:0]   acc_q;
  logic               accept;
  logic               calc_en;
  logic [HALF_W-1:0]  core_a, core_b;
  logic [PP_W-1:0]    pp;
  logic [ACC_W-1:0]   pp_ext;

`ifdef MUL32_SEQ_ZERO_SKIP_EN
  logic [3:0]         mask_q, mask_d;
  logic [3:0]         remaining;
`endif

  // Core halves are selected from the latched operands only, so input changes after accept are harmless.
  always_comb begin
    core_a = (step_q == STEP_HL || step_q == STEP_HH) ? a_q[31:16] : a_q[15:0];
    core_b = (step_q == STEP_LH || step_q == STEP_HH) ? b_q[31:16] : b_q[15:0];
    pp_ext = {{(ACC_W-PP_W){1'b0}}, pp} << step_shift(step_q);
  end

  mul32_seq_ctrl_core wallace_16 (
    .a (core_a),
    .b (core_b),
    .p (pp)
  );

  // Next-state, step sequencing and handshake outputs.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    accept    = 1'b0;
    calc_en   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
    mask_d    = mask_q;
    remaining = '0;
`endif
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept = 1'b1;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
          // A step contributes nothing when either of its operand halves is zero.
          mask_d[STEP_LL] = (in_a[15:0]  != '0) && (in_b[15:0]  != '0);
          mask_d[STEP_HL] = (in_a[31:16] != '0) && (in_b[15:0]  != '0);
          mask_d[STEP_LH] = (in_a[15:0]  != '0) && (in_b[31:16] != '0);
          mask_d[STEP_HH] = (in_a[31:16] != '0) && (in_b[31:16] != '0);
          step_d  = first_step(mask_d);
          state_d = (mask_d == '0) ? DONE : CALC;
`else
          step_d  = STEP_LL;
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        calc_en = 1'b1;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
        remaining = mask_q & later_steps(step_q);
        if (remaining == '0) begin
          state_d = DONE;
        end else begin
          step_d = first_step(remaining);
        end
`else
        if (step_q == STEP_HH) begin
          state_d = DONE;
        end else begin
          step_d = step_t'(step_q + 2'd1);
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and step register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= STEP_LL;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // Operand capture and shifted partial-product accumulation; carry out of bit 63 is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b;
      acc_q <= '0;
    end else if (calc_en) begin
      acc_q <= acc_q + pp_ext;
    end
  end

  assign out_p = acc_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb/tb_mul32_seq_ctrl.sv - scoreboard bench for mul32_seq_ctrl
module tb_mul32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] p;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mul32_seq_ctrl #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
`ifdef MUL32_SEQ_ZERO_SKIP_EN
    if (a[15:0]  != 0 && b[15:0]  != 0) n++;
    if (a[31:16] != 0 && b[15:0]  != 0) n++;
    if (a[15:0]  != 0 && b[31:16] != 0) n++;
    if (a[31:16] != 0 && b[31:16] != 0) n++;
`else
    n = 4;
`endif
    return 1 + n;
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.p   = {32'd0, a} * {32'd0, b};
    e.lat = model_lat(a, b);
    sb.push_back(e);
  endtask

  // One full transaction: accept, latency, product, optional backpressure, return to IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string name);
    exp_t e;
    int   k;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready_before: got %b expected 1", name, in_ready);
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    push_exp(a, b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = ~a;
    in_b = 32'h5A5A_A5A5;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (out_valid !== 1'b1 && k < 20);
    e = sb.pop_front();
    checks++;
    if (k !== e.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, k, e.lat);
    end
    checks++;
    if (out_p !== e.p) begin
      errors++;
      $display("FAIL %s_product: got %h expected %h", name, out_p, e.p);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_p !== e.p || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold%0d: got valid=%b p=%h in_ready=%b expected valid=1 p=%h in_ready=0",
                 name, i, out_valid, out_p, in_ready, e.p);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: got busy=%b in_ready=%b out_valid=%b expected 0/1/0",
               name, busy, in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_p !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b out_p=%h expected 0/0/0/0",
               in_ready, out_valid, busy, out_p);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_max;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max");
  endtask

  task automatic test_backpressure;
    run_op(32'd3, 32'd5, 3, "backpressure");
  endtask

  task automatic test_sparse;
    run_op(32'h0001_0000, 32'h0001_0000, 0, "sparse");
  endtask

  task automatic test_zero;
    run_op(32'd0, 32'h1234_5678, 0, "zero");
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    in_a = 32'hFFFF_FFFF;
    in_b = 32'h0002_0002;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got %b expected 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ready_in_reset: got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_p !== 64'd0) begin
      errors++;
      $display("FAIL midrst_after: got in_ready=%b out_valid=%b busy=%b out_p=%h expected 1/0/0/0",
               in_ready, out_valid, busy, out_p);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrst_no_output: got %0d valid cycles expected 0", seen);
    end
    run_op(32'h0001_0000, 32'h0001_0001, 0, "after_midrst");
  endtask

  task automatic test_back_to_back;
    int   acc_cyc[$];
    int   cyc;
    int   n_acc;
    int   outs;
    int   c0;
    exp_t e;
    @(negedge clk);
    out_ready = 1'b1;
    in_a = 32'd7;
    in_b = 32'd9;
    in_valid = 1'b1;
    push_exp(32'd7, 32'd9);
    cyc = 0;
    n_acc = 0;
    outs = 0;
    while (outs < 2 && cyc < 60) begin
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      if (out_valid === 1'b1) begin
        e = sb.pop_front();
        c0 = acc_cyc.pop_front();
        outs++;
        checks++;
        if (out_p !== e.p) begin
          errors++;
          $display("FAIL b2b_product%0d: got %h expected %h", outs, out_p, e.p);
        end
        checks++;
        if (cyc - c0 !== e.lat) begin
          errors++;
          $display("FAIL b2b_latency%0d: got %0d expected %0d", outs, cyc - c0, e.lat);
        end
      end
      @(posedge clk);
      #1;
      if (n_acc == 1 && in_a == 32'd7) begin
        in_a = 32'h0000_FFFF;
        in_b = 32'h0001_0000;
        push_exp(32'h0000_FFFF, 32'h0001_0000);
      end else if (n_acc == 2) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (outs !== 2) begin
      errors++;
      $display("FAIL b2b_outputs: got %0d expected 2", outs);
    end
    checks++;
    if (n_acc !== 2) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d expected 2", n_acc);
    end else begin
      c0 = acc_cyc.size() > 0 ? acc_cyc[0] : -1;
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL b2b_scoreboard_left: got %0d expected 0", sb.size());
    end
  endtask

  task automatic test_second_accept_cycle;
    int cyc;
    int first;
    int second;
    @(negedge clk);
    out_ready = 1'b1;
    in_a = 32'd7;
    in_b = 32'd9;
    in_valid = 1'b1;
    first = -1;
    second = -1;
    cyc = 0;
    while (second < 0 && cyc < 40) begin
      if (in_ready === 1'b1) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
      @(posedge clk);
      #1;
      in_a = 32'h0000_FFFF;
      in_b = 32'h0001_0000;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (second - first !== model_lat(32'd7, 32'd9) + 1) begin
      errors++;
      $display("FAIL b2b_second_accept_cycle: got %0d expected %0d",
               second - first, model_lat(32'd7, 32'd9) + 1);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_backpressure();
    test_sparse();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_second_accept_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
